// File: rtl/rs_frame_packer_if.sv
// Byte-wide AXI-Stream link used on both sides of rs_frame_packer.
//
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high. Once the master raises tvalid it holds tvalid, tdata and
// tlast unchanged until that transfer. tready may rise or fall at any time,
// and the master never waits for tready before raising tvalid.
interface rs_frame_packer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/rs_frame_packer.sv
// rs_frame_packer: puts a 4-byte attached sync marker in front of every RS
// codeword and forwards the codeword bytes with full backpressure.
// Codewords of the wrong length still end the output frame at the right
// place. A short codeword ends the frame early. A long codeword is cut at
// CW_LEN bytes and the rest of it is discarded. Both cases pulse len_err.
//
// Optional build macro RANDOMIZER_EN: XORs codeword bytes, but never ASM
// bytes, with the CCSDS pseudo-randomizer h(x) = x^8+x^7+x^5+x^3+1. The
// randomizer is seeded to 8'hFF at the start of each frame.
//
// state_dbg exposes the FSM state for checkers and debug.
module rs_frame_packer #(
  parameter int          CW_LEN = 255,
  parameter logic [31:0] ASM    = 32'h1ACFFC1D,
  parameter int          CNT_W  = 16
) (
  input  logic               core_clk,
  input  logic               rst,
  rs_frame_packer_if.slave   s_axis,
  rs_frame_packer_if.master  m_axis,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   len_err_cnt,
  output logic               len_err,
  output logic [1:0]         state_dbg
);

  // Width of the codeword byte counter. It counts 0 .. CW_LEN-1.
  localparam int BC_W = $clog2(CW_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ASM  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       asm_idx, asm_idx_nxt;
  logic [BC_W-1:0]  byte_cnt, byte_cnt_nxt;
  logic [BC_W:0]    byte_num;
  logic             at_len;

  logic [7:0]       out_data, out_data_nxt;
  logic             out_valid, out_valid_nxt;
  logic             out_last, out_last_nxt;

  logic             out_ld;
  logic             s_ready;
  logic             data_acc;
  logic             frame_done;
  logic             err_hit;
  logic             seed;
  logic [7:0]       asm_byte;
  logic [7:0]       data_byte;

  // The output register may take a new value when it is empty or its
  // current beat is being accepted this cycle.
  assign out_ld = !out_valid || m_axis.tready;

  // byte_num is the 1-based position of the byte offered right now.
  assign byte_num = {1'b0, byte_cnt} + (BC_W+1)'(1);
  assign at_len   = (byte_num == (BC_W+1)'(CW_LEN));

  // A codeword byte is consumed and forwarded on this edge.
  assign data_acc = (state == ST_DATA) && s_axis.tvalid && out_ld;

  // Select the marker byte to send, most significant byte first.
  always_comb begin
    asm_byte = ASM[31:24];
    case (asm_idx)
      2'd0:    asm_byte = ASM[31:24];
      2'd1:    asm_byte = ASM[23:16];
      2'd2:    asm_byte = ASM[15:8];
      default: asm_byte = ASM[7:0];
    endcase
  end

`ifdef RANDOMIZER_EN
  logic [7:0] lfsr;

  // Advance the randomizer by 8 bits. Bit 7 of the window is the oldest
  // sequence bit, so the window itself is the MSB-first output byte.
  function automatic logic [7:0] lfsr_adv(input logic [7:0] w);
    logic [7:0] t;
    t = w;
    for (int i = 0; i < 8; i++) begin
      t = {t[6:0], t[0] ^ t[2] ^ t[4] ^ t[7]};
    end
    return t;
  endfunction

  // Randomizer state: seeded on entry to ASM, stepped per forwarded byte.
  always_ff @(posedge core_clk) begin
    if (rst) begin
      lfsr <= 8'hFF;
    end else if (seed) begin
      lfsr <= 8'hFF;
    end else if (data_acc) begin
      lfsr <= lfsr_adv(lfsr);
    end
  end

  assign data_byte = s_axis.tdata ^ lfsr;
`else
  assign data_byte = s_axis.tdata;
`endif

  // Next-state logic, output register load and input ready.
  always_comb begin
    state_nxt     = state;
    asm_idx_nxt   = asm_idx;
    byte_cnt_nxt  = byte_cnt;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    out_last_nxt  = out_last;
    s_ready       = 1'b0;
    frame_done    = 1'b0;
    err_hit       = 1'b0;
    seed          = 1'b0;

    // If nothing new is loaded, the register empties once its beat is taken.
    if (out_ld) begin
      out_valid_nxt = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        // The waiting byte is only a trigger. It is consumed later, in DATA.
        if (s_axis.tvalid) begin
          state_nxt   = ST_ASM;
          asm_idx_nxt = 2'd0;
          seed        = 1'b1;
        end
      end

      ST_ASM: begin
        if (out_ld) begin
          out_data_nxt  = asm_byte;
          out_valid_nxt = 1'b1;
          out_last_nxt  = 1'b0;
          asm_idx_nxt   = asm_idx + 2'd1;
          if (asm_idx == 2'd3) begin
            state_nxt    = ST_DATA;
            byte_cnt_nxt = '0;
          end
        end
      end

      ST_DATA: begin
        s_ready = out_ld;
        if (data_acc) begin
          out_data_nxt  = data_byte;
          out_valid_nxt = 1'b1;
          out_last_nxt  = 1'b0;
          byte_cnt_nxt  = byte_cnt + BC_W'(1);
          // The frame ends on tlast or at CW_LEN, whichever comes first.
          // Both together is a good frame. Either one alone is a length
          // error.
          if (s_axis.tlast || at_len) begin
            out_last_nxt = 1'b1;
            frame_done   = 1'b1;
            err_hit      = s_axis.tlast ^ at_len;
            state_nxt    = s_axis.tlast ? ST_IDLE : ST_DROP;
          end
        end
      end

      default: begin
        // ST_DROP: swallow the rest of an overlong codeword.
        s_ready = 1'b1;
        if (s_axis.tvalid && s_axis.tlast) begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // State, output register and saturating counters.
  always_ff @(posedge core_clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      asm_idx     <= 2'd0;
      byte_cnt    <= '0;
      out_data    <= 8'h00;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      frame_cnt   <= '0;
      len_err_cnt <= '0;
      len_err     <= 1'b0;
    end else begin
      state     <= state_nxt;
      asm_idx   <= asm_idx_nxt;
      byte_cnt  <= byte_cnt_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
      len_err   <= err_hit;
      if (frame_done && (frame_cnt != {CNT_W{1'b1}})) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (err_hit && (len_err_cnt != {CNT_W{1'b1}})) begin
        len_err_cnt <= len_err_cnt + CNT_W'(1);
      end
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = out_data;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = out_last;
  assign state_dbg     = state;

endmodule

// File: tb/tb_rs_frame_packer.sv
// Directed bench for rs_frame_packer. The counters are built 2 bits wide
// here so that frame_cnt saturation is reached within a few frames. If
// RANDOMIZER_EN is defined, the expected codeword bytes are XORed with a
// randomizer sequence that the bench builds from the polynomial recurrence.
module tb_rs_frame_packer;

  localparam int CW_LEN = 255;
  localparam int CNT_W  = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;

  logic             core_clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] len_err_cnt;
  logic             len_err;
  logic [1:0]       state_dbg;

  rs_frame_packer_if s_axis();
  rs_frame_packer_if m_axis();

  rs_frame_packer #(
    .CW_LEN (CW_LEN),
    .ASM    (32'h1ACFFC1D),
    .CNT_W  (CNT_W)
  ) dut (
    .core_clk    (core_clk),
    .rst         (rst),
    .s_axis      (s_axis),
    .m_axis      (m_axis),
    .frame_cnt   (frame_cnt),
    .len_err_cnt (len_err_cnt),
    .len_err     (len_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 core_clk = ~core_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bookkeeping ----------------
  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  int          beats = 0;
  int          len_err_pulses = 0;
  int          stall_cycles = 0;
  int          rdy_mode = 0;
  int          stall_left = 0;
  logic        stall_prev = 1'b0;
  logic [8:0]  held = '0;
  logic [7:0]  prbs [0:CW_LEN-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int idx, input logic [7:0] d);
`ifdef RANDOMIZER_EN
    return d ^ prbs[idx];
`else
    return d;
`endif
  endfunction

  // ---------------- downstream ready driver ----------------
  // Mode 0: always ready. Mode 1: toggle every cycle, with random 3-cycle stalls.
  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge core_clk);
      #1;
      if (rdy_mode == 0) begin
        m_axis.tready = 1'b1;
      end else if (stall_left > 0) begin
        m_axis.tready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 7) == 0) begin
        m_axis.tready = 1'b0;
        stall_left = 2;
      end else begin
        m_axis.tready = ~m_axis.tready;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge core_clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", m_axis.tvalid, 1);
        check("hold_bits", {m_axis.tlast, m_axis.tdata}, held);
      end
      stall_prev = m_axis.tvalid && !m_axis.tready;
      if (stall_prev) stall_cycles++;
      held = {m_axis.tlast, m_axis.tdata};
      if (len_err) len_err_pulses++;
    end
    if (m_axis.tvalid && m_axis.tready) begin
      beats++;
      check("beat_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        check("beat", {m_axis.tlast, m_axis.tdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] d, input logic l, output int waited);
    s_axis.tdata  = d;
    s_axis.tvalid = 1'b1;
    s_axis.tlast  = l;
    waited = 0;
    forever begin
      @(negedge core_clk);
      if (s_axis.tready) break;
      waited++;
      if (waited > 200) begin
        check("push_timeout", waited, 0);
        break;
      end
    end
    @(posedge core_clk);
    #1;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  // Send n bytes (i or zero), tlast on the n-th. drop_wait sums the stall
  // cycles seen by the bytes past CW_LEN.
  task automatic send_frame(input int n, input bit zero, output int drop_wait);
    int w;
    drop_wait = 0;
    for (int i = 0; i < n; i++) begin
      push(zero ? 8'h00 : i[7:0], (i == n - 1), w);
      if (i >= CW_LEN) drop_wait += w;
    end
  endtask

  // Expected output of a codeword of n bytes: ASM, then at most CW_LEN
  // bytes, with tlast on the last byte forwarded.
  task automatic exp_frame(input int n, input bit zero);
    int fwd;
    fwd = (n < CW_LEN) ? n : CW_LEN;
    exp_q.push_back({1'b0, 8'h1A});
    exp_q.push_back({1'b0, 8'hCF});
    exp_q.push_back({1'b0, 8'hFC});
    exp_q.push_back({1'b0, 8'h1D});
    for (int i = 0; i < fwd; i++) begin
      exp_q.push_back({(i == fwd - 1), exp_byte(i, zero ? 8'h00 : i[7:0])});
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis.tvalid) && n < 3000) begin
      @(negedge core_clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int dw;
    logic [7:0] rseq [0:7];
    logic [2047:0] bits;

    // Randomizer reference: a[n+8] = a[n+7]^a[n+5]^a[n+3]^a[n], a[0..7]=1.
    bits = '0;
    for (int k = 0; k < 8; k++) bits[k] = 1'b1;
    for (int k = 8; k < CW_LEN * 8; k++) bits[k] = bits[k-1] ^ bits[k-3] ^ bits[k-5] ^ bits[k-8];
    for (int b = 0; b < CW_LEN; b++) begin
      for (int k = 0; k < 8; k++) prbs[b][7-k] = bits[b*8 + k];
    end

    rst = 1'b1;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = 8'h00;
    s_axis.tlast  = 1'b0;
    repeat (3) @(posedge core_clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_m_tvalid", m_axis.tvalid, 0);
    check("rst_m_tdata", m_axis.tdata, 0);
    check("rst_m_tlast", m_axis.tlast, 0);
    check("rst_s_tready", s_axis.tready, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_len_err_cnt", len_err_cnt, 0);
    check("rst_len_err", len_err, 0);
    check("rst_state", state_dbg, ST_IDLE);
    repeat (2) @(posedge core_clk);
    #1;
    check("idle_no_input", state_dbg, ST_IDLE);

    // Nominal 255-byte frame, downstream always ready
    beats = 0;
    exp_frame(255, 1'b0);
    send_frame(255, 1'b0, dw);
    wait_drain("t1_drain");
    check("t1_beats", beats, 259);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_len_err_cnt", len_err_cnt, 0);
    check("t1_len_err_pulses", len_err_pulses, 0);

    // Same frame under toggling ready and random stalls
    rdy_mode = 1;
    beats = 0;
    stall_cycles = 0;
    exp_frame(255, 1'b0);
    send_frame(255, 1'b0, dw);
    wait_drain("t2_drain");
    rdy_mode = 0;
    repeat (2) @(posedge core_clk);
    #1;
    check("t2_beats", beats, 259);
    check("t2_stalls_seen", (stall_cycles > 0), 1);
    check("t2_frame_cnt", frame_cnt, 2);

    // Short codeword of 10 bytes
    exp_frame(10, 1'b0);
    send_frame(10, 1'b0, dw);
    wait_drain("t3_drain");
    check("t3_len_err_cnt", len_err_cnt, 1);
    check("t3_len_err_pulses", len_err_pulses, 1);
    check("t3_frame_cnt", frame_cnt, 3);

    // Correct frame after the short one; frame_cnt is saturated at 3
    exp_frame(255, 1'b0);
    send_frame(255, 1'b0, dw);
    wait_drain("t3b_drain");
    check("t3b_frame_cnt_sat", frame_cnt, 3);
    check("t3b_len_err_cnt", len_err_cnt, 1);
    check("t3b_len_err_pulses", len_err_pulses, 1);

    // Long codeword of 300 bytes: cut at 255, rest dropped with ready held
    exp_frame(300, 1'b0);
    send_frame(300, 1'b0, dw);
    wait_drain("t4_drain");
    check("t4_drop_wait", dw, 0);
    check("t4_len_err_cnt", len_err_cnt, 2);
    check("t4_len_err_pulses", len_err_pulses, 2);
    check("t4_state", state_dbg, ST_IDLE);

    // Next frame after DROP starts with ASM
    exp_frame(255, 1'b0);
    send_frame(255, 1'b0, dw);
    wait_drain("t4b_drain");
    check("t4b_len_err_cnt", len_err_cnt, 2);

    // Reset after 100 data bytes of a frame
    exp_q.push_back({1'b0, 8'h1A});
    exp_q.push_back({1'b0, 8'hCF});
    exp_q.push_back({1'b0, 8'hFC});
    exp_q.push_back({1'b0, 8'h1D});
    for (int i = 0; i < 100; i++) exp_q.push_back({1'b0, exp_byte(i, i[7:0])});
    for (int i = 0; i < 100; i++) push(i[7:0], 1'b0, dw);
    rst = 1'b1;
    @(posedge core_clk);
    #1;
    rst = 1'b0;
    check("t5_m_tvalid", m_axis.tvalid, 0);
    check("t5_frame_cnt", frame_cnt, 0);
    check("t5_len_err_cnt", len_err_cnt, 0);
    check("t5_state", state_dbg, ST_IDLE);
    check("t5_partial_sent", exp_q.size(), 0);

    // Fresh frame after reset
    exp_frame(255, 1'b0);
    send_frame(255, 1'b0, dw);
    wait_drain("t5b_drain");
    check("t5b_frame_cnt", frame_cnt, 1);
    check("t5b_len_err_cnt", len_err_cnt, 0);

`ifdef RANDOMIZER_EN
    // Reference sequence matches the published start, then two zero frames
    rseq[0] = 8'hFF; rseq[1] = 8'h48; rseq[2] = 8'h0E; rseq[3] = 8'hC0;
    rseq[4] = 8'h9A; rseq[5] = 8'h0D; rseq[6] = 8'h70; rseq[7] = 8'hBC;
    for (int i = 0; i < 8; i++) check("prbs_ref", prbs[i], rseq[i]);
    exp_frame(255, 1'b1);
    send_frame(255, 1'b1, dw);
    wait_drain("t6_drain");
    exp_frame(255, 1'b1);
    send_frame(255, 1'b1, dw);
    wait_drain("t6b_drain");
    check("t6_frame_cnt", frame_cnt, 3);
`else
    rseq[0] = 8'h00;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
